led_sequencer: RTL and testbench
================================

Name: led_sequencer

Overview:
- Consumes the slow toggle output of a clock divider and steps a 4-LED light pattern once per toggle edge.
- A debounced pushbutton cycles through four pattern modes.
- Sits directly downstream of the divider. Its outputs drive the board LEDs in place of the raw divided clocks.
- Single clock domain: i_Clk (25 MHz).

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clocks a synchronised button level must hold before it is accepted (10 ms at 25 MHz); legal range 2..2^18-1.
- STEP_BOTH_EDGES, 1, 1 = step on rising and falling edges of i_Tick; 0 = step on rising edge only.

Ports:
- i_Clk  in  1  system clock, 25 MHz.
- i_Rst_L  in  1  asynchronous, active-low reset; deassertion synchronous to i_Clk.
- i_Tick  in  1  divided clock level from the divider; already in the i_Clk domain, so no synchroniser.
- i_Switch_1  in  1  raw pushbutton, high = pressed; asynchronous, bouncing.
- o_LED_1..o_LED_4  out  1 each  pattern outputs, high = lit.
- o_Mode  out  2  current mode.

Behaviour:
- Reset (i_Rst_L low, immediate, asynchronous), values take effect while reset is held:
  - mode = 0, pos = 0, dir = up, phase = 1.
  - r_Tick_Prev = 0.
  - Sync flops = 0, debounced = 0, debounce count = 0.
  - Outputs: o_LED_1 = 1, others 0, o_Mode = 0.
- Step detection:
  - step = i_Tick XOR r_Tick_Prev, or (i_Tick AND NOT r_Tick_Prev) when STEP_BOTH_EDGES = 0.
  - r_Tick_Prev <= i_Tick every clock.
  - Pattern state updates on the same rising edge that first samples the changed i_Tick. LEDs change with zero extra cycles after that edge.
- LED outputs:
  - Combinational decode of registered mode, pos, and phase.
  - o_LED_(pos+1) lit in chase and bounce modes.
  - All four = phase in BLINK mode.
- Modes:
  - 0 CHASE_R: pos 0→1→2→3→0.
  - 1 CHASE_L: pos 0→3→2→1→0.
  - 2 BOUNCE: pos 0,1,2,3,2,1,0,1,…
    - dir flips when moving up from pos 3 or down from pos 0.
    - Each end position is held for exactly one step; never repeated.
  - 3 BLINK: phase toggles each step; pos unused.
- Debounce, in sub-module:
  - 2-FF synchroniser into sync.
  - If sync == debounced, count = 0.
  - Else count increments. When count == DEBOUNCE_CYCLES-1: debounced <= sync and count <= 0.
  - Any return of sync to the debounced value before then clears count.
  - Count width 18 bits.
- Mode advance:
  - release = debounced 1→0, detected with a registered copy of debounced.
  - On release, mode <= mode+1, wrapping 3→0.
  - On the same edge, pos = 0, dir = up, phase = 1.
- Simultaneous release and step: release wins. Pattern restarts at pos 0 and that step is discarded.
- i_Tick stuck (divider idle): pattern holds indefinitely. No timeout.
- Press with no release: no mode change.
- Reset mid-pattern or mid-debounce: all state returns to reset values immediately. A button held through reset produces no release until it is pressed and released again.

Decomposition:
- Include file blink_defs.vh:
  - Mode encodings MODE_CHASE_R = 2'd0, MODE_CHASE_L = 2'd1, MODE_BOUNCE = 2'd2, MODE_BLINK = 2'd3.
  - Default DEBOUNCE_CYCLES.
  - The existing ONE_HZ..FIVE_HZ cycle-count defines move here as well.
- One sub-module, debounce_filter:
  - Ports: i_Clk, i_Rst_L, i_Raw, o_Level.
  - Parameter: CYCLES.
  - Contains the synchroniser and the filter.
- led_sequencer instantiates debounce_filter and holds the edge detect, the mode/pos/dir/phase registers, and the LED decode.

Test Plan (DEBOUNCE_CYCLES = 4, STEP_BOTH_EDGES = 1 unless stated):
1. Reset then 5 i_Tick toggles in mode 0 -> LED one-hot after each toggle: 2,3,4,1,2 (LED index). o_Mode = 0 throughout.
2. Mode 2, 8 toggles -> LED sequence 2,3,4,3,2,1,2,3. No end LED repeated.
3. i_Switch_1 bounce pattern 1,0,1,1,1,1,1 then a clean 0 held for 8 clocks:
   - o_Mode increments exactly once, 0→1.
   - Increment occurs 2 (sync) + 4 (filter) + 1 (edge) clocks after the final 0 is applied.
   - The glitch sequence alone produces no change.
4. Release event and i_Tick toggle on the same clock while in mode 0 at pos 2 -> o_Mode = 1, LED_1 lit, no step applied. The next toggle gives LED_4 (chase-left from pos 0).
5. Mode 3, 4 toggles -> all LEDs 0,1,0,1. Four further releases wrap o_Mode 3→0→1→2→3.
6. Assert i_Rst_L low asynchronously mid-pattern and mid-debounce count -> outputs are reset values (LED_1 = 1, o_Mode = 0) before the next clock edge. With STEP_BOTH_EDGES = 0, only rising toggles advance pos.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: mode encodings, debounce
// default and the divider toggle counts for a 25 MHz clock.
package led_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE_R = 2'd0,
    MODE_CHASE_L = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned CountWidth              = 18;

  // Half-period cycle counts: the divider toggles its output after this many clocks.
  localparam int unsigned ONE_HZ   = 12500000;
  localparam int unsigned TWO_HZ   = 6250000;
  localparam int unsigned THREE_HZ = 4166667;
  localparam int unsigned FOUR_HZ  = 3125000;
  localparam int unsigned FIVE_HZ  = 2500000;

endpackage

// File: rtl/led_sequencer_debounce_filter.sv
// Two-flop synchroniser plus a hold-time filter: a new level is accepted only
// after it has been stable for CYCLES consecutive clocks.
module debounce_filter
  import led_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Level
);

  localparam logic [CountWidth-1:0] CountLast = CountWidth'(CYCLES - 1);

  logic                  sync1_q;
  logic                  sync_q;
  logic                  level_q;
  logic [CountWidth-1:0] count_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= i_Raw;
      sync_q  <= sync1_q;
      if (sync_q == level_q) begin
        count_q <= '0;
      end else if (count_q == CountLast) begin
        level_q <= sync_q;
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign o_Level = level_q;

endmodule

// File: rtl/led_sequencer.sv
// Steps a 4-LED pattern on each edge of the divider tick; a debounced button
// release advances through chase-right, chase-left, bounce and blink modes.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          STEP_BOTH_EDGES = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Tick,
  input  logic       i_Switch_1,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  logic       level;
  logic       level_q;
  logic       tick_prev_q;
  mode_e      mode_q;
  logic [1:0] pos_q;
  logic       dir_up_q;
  logic       phase_q;
  logic       step;
  logic       release_evt;
  logic [3:0] leds;

  debounce_filter #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Raw   (i_Switch_1),
    .o_Level (level)
  );

  assign step        = STEP_BOTH_EDGES ? (i_Tick ^ tick_prev_q) : (i_Tick & ~tick_prev_q);
  assign release_evt = level_q & ~level;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tick_prev_q <= 1'b0;
      level_q     <= 1'b0;
      mode_q      <= MODE_CHASE_R;
      pos_q       <= 2'd0;
      dir_up_q    <= 1'b1;
      phase_q     <= 1'b1;
    end else begin
      tick_prev_q <= i_Tick;
      level_q     <= level;
      // A release restarts the pattern and swallows any coincident step.
      if (release_evt) begin
        mode_q   <= mode_e'(mode_q + 2'd1);
        pos_q    <= 2'd0;
        dir_up_q <= 1'b1;
        phase_q  <= 1'b1;
      end else if (step) begin
        unique case (mode_q)
          MODE_CHASE_R: pos_q <= pos_q + 2'd1;
          MODE_CHASE_L: pos_q <= pos_q - 2'd1;
          MODE_BOUNCE: begin
            // Turn around at the ends so each end position shows for one step only.
            if (dir_up_q) begin
              if (pos_q == 2'd3) begin
                dir_up_q <= 1'b0;
                pos_q    <= 2'd2;
              end else begin
                pos_q <= pos_q + 2'd1;
              end
            end else begin
              if (pos_q == 2'd0) begin
                dir_up_q <= 1'b1;
                pos_q    <= 2'd1;
              end else begin
                pos_q <= pos_q - 2'd1;
              end
            end
          end
          MODE_BLINK: phase_q <= ~phase_q;
          default: pos_q <= pos_q;
        endcase
      end
    end
  end

  always_comb begin
    leds = 4'b0000;
    if (mode_q == MODE_BLINK) begin
      leds = {4{phase_q}};
    end else begin
      leds[pos_q] = 1'b1;
    end
  end

  assign o_LED_1 = leds[0];
  assign o_LED_2 = leds[1];
  assign o_LED_3 = leds[2];
  assign o_LED_4 = leds[3];
  assign o_Mode  = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: one both-edge instance and one rising-only instance
// share stimulus; expected LED/mode values are hand-derived per scenario.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       sw = 1'b0;
  logic       l1_a, l2_a, l3_a, l4_a;
  logic       l1_b, l2_b, l3_b, l4_b;
  logic [1:0] mode_a, mode_b;
  logic [3:0] leds_a, leds_b;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign leds_a = {l4_a, l3_a, l2_a, l1_a};
  assign leds_b = {l4_b, l3_b, l2_b, l1_b};

  led_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .STEP_BOTH_EDGES (1'b1)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Tick     (tick),
    .i_Switch_1 (sw),
    .o_LED_1    (l1_a),
    .o_LED_2    (l2_a),
    .o_LED_3    (l3_a),
    .o_LED_4    (l4_a),
    .o_Mode     (mode_a)
  );

  led_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .STEP_BOTH_EDGES (1'b0)
  ) dut_rise (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Tick     (tick),
    .i_Switch_1 (sw),
    .o_LED_1    (l1_b),
    .o_LED_2    (l2_b),
    .o_LED_3    (l3_b),
    .o_LED_4    (l4_b),
    .o_Mode     (mode_b)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b0;
    sw    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    @(negedge clk);
    tick = ~tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    @(negedge clk);
    sw = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    sw = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (leds_a !== 4'b0001 || mode_a !== 2'd0) begin
      failures++;
      $display("FAIL reset_a got leds=%b mode=%0d expected leds=0001 mode=0", leds_a, mode_a);
    end
    checks++;
    if (leds_b !== 4'b0001 || mode_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_b got leds=%b mode=%0d expected leds=0001 mode=0", leds_b, mode_b);
    end
    do_reset();
  endtask

  task automatic test_chase_r();
    logic [3:0] exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      toggle();
      checks++;
      if (leds_a !== exp[i] || mode_a !== 2'd0) begin
        failures++;
        $display("FAIL chase_r[%0d] got leds=%b mode=%0d expected leds=%b mode=0",
                 i, leds_a, mode_a, exp[i]);
      end
    end
  endtask

  task automatic test_debounce();
    logic [6:0] pat = 7'b1111101;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sw = pat[i];
    end
    @(negedge clk);
    sw = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (mode_a !== ((k < 7) ? 2'd0 : 2'd1)) begin
        failures++;
        $display("FAIL debounce_clk%0d got mode=%0d expected %0d", k, mode_a, (k < 7) ? 0 : 1);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (mode_a !== 2'd1 || leds_a !== 4'b0001) begin
      failures++;
      $display("FAIL debounce_settle got mode=%0d leds=%b expected mode=1 leds=0001",
               mode_a, leds_a);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                            4'b0010, 4'b0001, 4'b0010, 4'b0100};
    press_release();
    checks++;
    if (mode_a !== 2'd2) begin
      failures++;
      $display("FAIL bounce_mode got %0d expected 2", mode_a);
    end
    for (int i = 0; i < 8; i++) begin
      toggle();
      checks++;
      if (leds_a !== exp[i]) begin
        failures++;
        $display("FAIL bounce[%0d] got leds=%b expected %b", i, leds_a, exp[i]);
      end
    end
  endtask

  task automatic test_release_vs_step();
    do_reset();
    toggle();
    toggle();
    checks++;
    if (leds_a !== 4'b0100) begin
      failures++;
      $display("FAIL rvs_pos2 got leds=%b expected 0100", leds_a);
    end
    @(negedge clk);
    sw = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    sw = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    tick = ~tick;
    @(posedge clk);
    #1;
    checks++;
    if (mode_a !== 2'd1 || leds_a !== 4'b0001) begin
      failures++;
      $display("FAIL rvs_same_edge got mode=%0d leds=%b expected mode=1 leds=0001",
               mode_a, leds_a);
    end
    toggle();
    checks++;
    if (leds_a !== 4'b1000) begin
      failures++;
      $display("FAIL rvs_chase_l got leds=%b expected 1000", leds_a);
    end
  endtask

  task automatic test_blink_wrap();
    logic [3:0] exp [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    logic [1:0] exp_mode [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    press_release();
    press_release();
    checks++;
    if (mode_a !== 2'd3 || leds_a !== 4'b1111) begin
      failures++;
      $display("FAIL blink_entry got mode=%0d leds=%b expected mode=3 leds=1111", mode_a, leds_a);
    end
    for (int i = 0; i < 4; i++) begin
      toggle();
      checks++;
      if (leds_a !== exp[i]) begin
        failures++;
        $display("FAIL blink[%0d] got leds=%b expected %b", i, leds_a, exp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      press_release();
      checks++;
      if (mode_a !== exp_mode[i]) begin
        failures++;
        $display("FAIL wrap[%0d] got mode=%0d expected %0d", i, mode_a, exp_mode[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    toggle();
    checks++;
    if (leds_a !== 4'b0000) begin
      failures++;
      $display("FAIL async_pre got leds=%b expected 0000", leds_a);
    end
    @(negedge clk);
    sw = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    checks++;
    if (leds_a !== 4'b0001 || mode_a !== 2'd0) begin
      failures++;
      $display("FAIL async_reset got leds=%b mode=%0d expected leds=0001 mode=0", leds_a, mode_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (mode_a !== 2'd0 || leds_a !== 4'b0001) begin
      failures++;
      $display("FAIL held_press got mode=%0d leds=%b expected mode=0 leds=0001", mode_a, leds_a);
    end
    @(negedge clk);
    sw = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (mode_a !== 2'd1) begin
      failures++;
      $display("FAIL held_release got mode=%0d expected 1", mode_a);
    end
  endtask

  task automatic test_rising_only();
    logic [3:0] exp_b [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100};
    logic [3:0] exp_a [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      toggle();
      checks++;
      if (leds_b !== exp_b[i] || mode_b !== 2'd0) begin
        failures++;
        $display("FAIL rise_only[%0d] got leds=%b mode=%0d expected leds=%b mode=0",
                 i, leds_b, mode_b, exp_b[i]);
      end
      checks++;
      if (leds_a !== exp_a[i]) begin
        failures++;
        $display("FAIL both_edges[%0d] got leds=%b expected %b", i, leds_a, exp_a[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chase_r();
    test_debounce();
    test_bounce();
    test_release_vs_step();
    test_blink_wrap();
    test_async_reset();
    test_rising_only();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
